// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, branch/jump resolution and IF/ID valid tracking.
// Optional redirect/stall statistics counters are built when IFU_STATS_EN is defined.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          STAT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [1:0]        branch_type_i,
    input  logic              jump_i,
    input  logic              zero_i,
    input  logic              neg_i,
    input  logic [31:0]       branch_target_i,
    input  logic [31:0]       jump_target_i,
    output logic [31:0]       imem_addr_o,
    output logic              imem_en_o,
    input  logic [31:0]       imem_data_i,
    output logic [31:0]       instr_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       pc_plus4_o,
    output logic              valid_o,
    output logic              flush_o,
    output logic [STAT_W-1:0] redirect_cnt_o,
    output logic [STAT_W-1:0] stall_cnt_o
);
    logic [31:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, target;
    logic        rsp_valid_q, rsp_valid_d, cond, redirect;

    always_comb begin
        cond = branch_type_i == 2'b00 ? zero_i :
               branch_type_i == 2'b01 ? ~zero_i & ~neg_i :
               branch_type_i == 2'b10 ? ~neg_i : ~zero_i;
        redirect = jump_i | (branch_i & cond);
        target = jump_i ? {jump_target_i[31:2], 2'b00} : {branch_target_i[31:2], 2'b00};
        imem_addr_o = redirect ? target : pc_q;
        imem_en_o = ~rst_i & (redirect | ~stall_i);
        flush_o = redirect & ~rst_i;
        pc_d = imem_en_o ? imem_addr_o + 32'd4 : pc_q;
        rsp_pc_d = imem_en_o ? imem_addr_o : rsp_pc_q;
        rsp_valid_d = imem_en_o | rsp_valid_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q        <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            rsp_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // The memory holds its output while disabled, so instr_o needs no register here.
    assign instr_o    = imem_data_i;
    assign pc_o       = rsp_pc_q;
    assign pc_plus4_o = rsp_pc_q + 32'd4;
    assign valid_o    = rsp_valid_q;

`ifdef IFU_STATS_EN
    logic [STAT_W-1:0] redir_cnt_q, redir_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        redir_cnt_d = (flush_o && !(&redir_cnt_q)) ? redir_cnt_q + STAT_W'(1) : redir_cnt_q;
        stall_cnt_d = (stall_i && !redirect && !rst_i && !(&stall_cnt_q)) ? stall_cnt_q + STAT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            redir_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            redir_cnt_q <= redir_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign redirect_cnt_o = redir_cnt_q;
    assign stall_cnt_o    = stall_cnt_q;
`else
    assign redirect_cnt_o = '0;
    assign stall_cnt_o    = '0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch sequencing, stalls, redirects and reset.
// Counter saturation checks run when IFU_STATS_EN is defined.
module tb_instr_fetch_unit;
    logic        clk_i = 1'b0;
    logic        rst_i, stall_i, branch_i, jump_i, zero_i, neg_i;
    logic [1:0]  branch_type_i;
    logic [31:0] branch_target_i, jump_target_i, imem_addr_o, imem_data_i;
    logic [31:0] instr_o, pc_o, pc_plus4_o;
    logic        imem_en_o, valid_o, flush_o;
    logic [3:0]  redirect_cnt_o, stall_cnt_o;
    int          checks = 0;
    int          errors = 0;

    instr_fetch_unit #(.RESET_PC(32'h0), .STAT_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .branch_i(branch_i),
        .branch_type_i(branch_type_i), .jump_i(jump_i), .zero_i(zero_i), .neg_i(neg_i),
        .branch_target_i(branch_target_i), .jump_target_i(jump_target_i),
        .imem_addr_o(imem_addr_o), .imem_en_o(imem_en_o), .imem_data_i(imem_data_i),
        .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .valid_o(valid_o),
        .flush_o(flush_o), .redirect_cnt_o(redirect_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Synchronous-read instruction memory that holds its output when disabled.
    always_ff @(posedge clk_i) if (imem_en_o) imem_data_i <= mem(imem_addr_o);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr();
        stall_i = 0; branch_i = 0; jump_i = 0; zero_i = 0; neg_i = 0;
        branch_type_i = 2'b00; branch_target_i = 0; jump_target_i = 0;
    endtask

    initial begin
        rst_i = 1; clr();
        tick(); tick();
        chk("rst_valid", valid_o, 0);
        chk("rst_en", imem_en_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_addr", imem_addr_o, 0);
        jump_i = 1; jump_target_i = 32'h200; #1;
        chk("rst_flush", flush_o, 0);
        chk("rst_jump_en", imem_en_o, 0);
        clr(); rst_i = 0; #1;
        chk("first_addr", imem_addr_o, 32'h0);
        chk("first_en", imem_en_o, 1);
        tick();
        chk("run_valid", valid_o, 1);
        chk("run_pc0", pc_o, 32'h0);
        chk("run_instr0", instr_o, mem(32'h0));
        chk("run_pc4_0", pc_plus4_o, 32'h4);
        chk("run_addr4", imem_addr_o, 32'h4);
        tick();
        chk("run_addr8", imem_addr_o, 32'h8);
        tick();
        chk("run_pc8", pc_o, 32'h8);
        stall_i = 1; #1;
        chk("stall_en", imem_en_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc_o, 32'h8);
            chk("stall_instr", instr_o, mem(32'h8));
            chk("stall_valid", valid_o, 1);
            chk("stall_addr", imem_addr_o, 32'hC);
        end
        stall_i = 0; tick();
        chk("rel_pc", pc_o, 32'hC);
        chk("rel_addr", imem_addr_o, 32'h10);
        branch_i = 1; branch_type_i = 2'b00; zero_i = 1; branch_target_i = 32'h40; #1;
        chk("beq_addr", imem_addr_o, 32'h40);
        chk("beq_flush", flush_o, 1);
        tick(); clr(); #1;
        chk("beq_pc", pc_o, 32'h40);
        chk("beq_instr", instr_o, mem(32'h40));
        chk("beq_next", imem_addr_o, 32'h44);
        chk("beq_noflush", flush_o, 0);
        branch_i = 1; zero_i = 0; branch_target_i = 32'h40; #1;
        chk("beqnt_addr", imem_addr_o, 32'h44);
        chk("beqnt_flush", flush_o, 0);
        tick();
        chk("beqnt_pc", pc_o, 32'h44);
        branch_type_i = 2'b01; zero_i = 0; neg_i = 0; branch_target_i = 32'h80; #1;
        chk("bgt_t", imem_addr_o, 32'h80);
        neg_i = 1; #1;
        chk("bgt_nt", imem_addr_o, 32'h48);
        chk("bgt_nt_flush", flush_o, 0);
        branch_type_i = 2'b10; zero_i = 1; neg_i = 0; #1;
        chk("bgez_t", imem_addr_o, 32'h80);
        branch_type_i = 2'b11; zero_i = 1; #1;
        chk("bnez_nt", imem_addr_o, 32'h48);
        zero_i = 0; branch_target_i = 32'h43; #1;
        chk("align_addr", imem_addr_o, 32'h40);
        tick(); clr(); #1;
        chk("align_pc", pc_o, 32'h40);
        jump_i = 1; jump_target_i = 32'h100; branch_i = 1; branch_type_i = 2'b00;
        zero_i = 1; branch_target_i = 32'h40; stall_i = 1; #1;
        chk("prio_addr", imem_addr_o, 32'h100);
        chk("prio_en", imem_en_o, 1);
        chk("prio_flush", flush_o, 1);
        tick(); clr(); #1;
        chk("prio_pc", pc_o, 32'h100);
        chk("prio_valid", valid_o, 1);
        jump_i = 1; jump_target_i = 32'hFFFF_FFFE; #1;
        chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        tick(); clr(); #1;
        chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4_o, 32'h0);
        chk("wrap_next", imem_addr_o, 32'h0);
`ifdef IFU_STATS_EN
        rst_i = 1; tick(); rst_i = 0;
        chk("cnt_rst_r", redirect_cnt_o, 0);
        for (int i = 0; i < 20; i++) begin
            jump_i = 1; jump_target_i = 32'h20 + 32'(i * 4); tick();
        end
        clr();
        chk("cnt_sat", redirect_cnt_o, 4'hF);
        stall_i = 1; tick(); tick();
        chk("cnt_stall", stall_cnt_o, 4'h2);
        rst_i = 1; tick();
        chk("cnt_clr", redirect_cnt_o, 0);
        chk("cnt_clr_s", stall_cnt_o, 0);
        chk("cnt_valid", valid_o, 0);
`else
        stall_i = 1; tick(); jump_i = 1; tick(); clr();
        chk("cnt_off_r", redirect_cnt_o, 0);
        chk("cnt_off_s", stall_cnt_o, 0);
        stall_i = 1; tick();
        rst_i = 1; tick();
`endif
        chk("midstall_valid", valid_o, 0);
        chk("midstall_pc", pc_o, 32'h0);
        chk("midstall_en", imem_en_o, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
